shreg_universal: RTL and testbench



---
 rtl/shreg_universal_if.sv | 39 +++
 rtl/shreg_universal.sv | 120 ++++++++++++
 tb/tb_shreg_universal.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/shreg_universal_if.sv
// Bus bundle for shreg_universal: command/data inputs plus register and status outputs.
// SHREG_PARITY_EN adds the registered parity output.
interface shreg_universal_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
    logic               enable_ext;
    logic               start_ext;
    logic [2:0]         mode_ext;
    logic [SHAMT_W-1:0] shamt_ext;
    logic [WIDTH-1:0]   d_ext;
    logic               sin_ext;
    logic [WIDTH-1:0]   q;
    logic               sout;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;
`ifdef SHREG_PARITY_EN
    logic               parity;
`endif

    // Handshake: start_ext is a strobe taken only in IDLE while enable_ext=1; busy marks SHIFT,
    // done marks the single DONE cycle, and neither input nor output waits on the other side.
    modport master (
        output enable_ext, start_ext, mode_ext, shamt_ext, d_ext, sin_ext,
        input  q, sout, busy, done, dbg_state
`ifdef SHREG_PARITY_EN
        , input parity
`endif
    );

    modport slave (
        input  enable_ext, start_ext, mode_ext, shamt_ext, d_ext, sin_ext,
        output q, sout, busy, done, dbg_state
`ifdef SHREG_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/shreg_universal.sv
// Universal shift register with multi-step shift/rotate commands and busy/done status.
// Optional feature macro: SHREG_PARITY_EN (registered even parity of q).
module shreg_universal #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic              clk,
    input  logic              rst_ext_n,
    shreg_universal_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_ROR   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;

    logic [2:0]         step_mode;
    logic [WIDTH-1:0]   step_q;
    logic               step_sout;
    logic               cmd_is_shift;

    // In IDLE the first step uses the incoming command; afterwards the captured one.
    always_comb begin
        step_mode = (state_q == S_IDLE) ? bus.mode_ext : mode_q;
        step_q    = q_q;
        step_sout = sout_q;
        case (step_mode)
            M_SHL: begin step_q = {q_q[WIDTH-2:0], bus.sin_ext}; step_sout = q_q[WIDTH-1]; end
            M_SHR: begin step_q = {bus.sin_ext, q_q[WIDTH-1:1]}; step_sout = q_q[0];       end
            M_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sout = q_q[WIDTH-1]; end
            M_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};       step_sout = q_q[0];       end
            M_ASR: begin step_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; step_sout = q_q[0];       end
            default: ;
        endcase
    end

    always_comb begin
        cmd_is_shift = (bus.mode_ext != M_HOLD) && (bus.mode_ext != M_LOAD) &&
                       (bus.mode_ext != M_CLEAR);
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        sout_d  = sout_q;
        if (bus.enable_ext) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_ext) begin
                        mode_d  = bus.mode_ext;
                        state_d = S_DONE;
                        if (!cmd_is_shift) begin
                            if (bus.mode_ext == M_LOAD)  q_d = bus.d_ext;
                            if (bus.mode_ext == M_CLEAR) q_d = '0;
                        end else if (bus.shamt_ext != '0) begin
                            q_d    = step_q;
                            sout_d = step_sout;
                            cnt_d  = bus.shamt_ext - SHAMT_W'(1);
                            if (bus.shamt_ext != SHAMT_W'(1)) state_d = S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    q_d    = step_q;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= M_HOLD;
            q_q     <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
        end
    end

`ifdef SHREG_PARITY_EN
    logic parity_q;
    // q_d equals q_q whenever the edge is disabled, so parity tracks q without its own enable.
    always_ff @(posedge clk or negedge rst_ext_n) begin
        if (!rst_ext_n) parity_q <= 1'b0;
        else            parity_q <= ^q_d;
    end
    assign bus.parity = parity_q;
`endif

    assign bus.q         = q_q;
    assign bus.sout      = sout_q;
    assign bus.busy      = (state_q == S_SHIFT);
    assign bus.done      = (state_q == S_DONE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_shreg_universal.sv
// Directed and randomized bench for shreg_universal against an arithmetic reference model.
module tb_shreg_universal;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int unsigned MASK = (1 << W) - 1;

  logic clk;
  logic rst_ext_n;
  int   checks;
  int   errors;

  logic [W-1:0] m_q;
  logic         m_sout;
  logic [W-1:0] exp_q[$];

  shreg_universal_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
  shreg_universal #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst_ext_n(rst_ext_n), .bus(bus));

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_busy, input logic exp_done);
    check({tag, ".q"}, bus.q, m_q);
    check({tag, ".sout"}, W'(bus.sout), W'(m_sout));
    check({tag, ".busy"}, W'(bus.busy), W'(exp_busy));
    check({tag, ".done"}, W'(bus.done), W'(exp_done));
`ifdef SHREG_PARITY_EN
    check({tag, ".parity"}, W'(bus.parity), W'(^m_q));
`endif
  endtask

  // reference: one shift/rotate step as plain arithmetic on the register value
  function automatic void model_step(input logic [2:0] m, input logic s);
    int unsigned v, so;
    v  = m_q;
    so = m_sout;
    case (m)
      3'd2: begin so = (v >> (W-1)) & 1; v = ((v << 1) | s) & MASK; end
      3'd3: begin so = v & 1; v = (v >> 1) | (int'(s) << (W-1)); end
      3'd4: begin so = (v >> (W-1)) & 1; v = ((v << 1) | so) & MASK; end
      3'd5: begin so = v & 1; v = (v >> 1) | (so << (W-1)); end
      3'd6: begin so = v & 1; v = (v >> 1) | (v & (1 << (W-1))); end
      default: ;
    endcase
    m_q    = v[W-1:0];
    m_sout = so[0];
  endfunction

  task automatic drive_noise();
    bus.start_ext = 1'($urandom);
    bus.mode_ext  = 3'($urandom);
    bus.shamt_ext = SW'($urandom);
    bus.d_ext     = W'($urandom);
  endtask

  // driver: issue one command from IDLE (called at a negedge), follow it back to IDLE.
  // sin_sel: 0/1 fixed serial bit, 2 random. stall_after: step after which enable drops 2 cycles.
  task automatic cmd(input logic [2:0] mode, input logic [SW-1:0] sh, input logic [W-1:0] d,
                     input bit noisy, input int sin_sel, input int stall_after);
    bit sh_op;
    int total;
    sh_op = (mode >= 3'd2) && (mode <= 3'd6);
    total = (sh_op && sh != 0) ? int'(sh) : 1;
    bus.start_ext = 1'b1;
    bus.mode_ext  = mode;
    bus.shamt_ext = sh;
    bus.d_ext     = d;
    bus.sin_ext   = (sin_sel == 2) ? 1'($urandom) : 1'(sin_sel);
    for (int k = 1; k <= total; k++) begin
      @(posedge clk);
      if (!sh_op) begin
        if (mode == 3'd1) m_q = d;
        if (mode == 3'd7) m_q = '0;
      end else if (sh != 0) begin
        model_step(mode, bus.sin_ext);
      end
      exp_q.push_back(m_q);
      @(negedge clk);
      check_all("step", k < total, k == total);
      if (noisy) drive_noise();
      else bus.start_ext = 1'b0;
      bus.sin_ext = (sin_sel == 2) ? 1'($urandom) : 1'(sin_sel);
      if (k == stall_after) begin
        bus.enable_ext = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check_all("stall", k < total, k == total);
          drive_noise();
        end
        bus.enable_ext = 1'b1;
      end
    end
    @(negedge clk);
    check_all("idle_after", 1'b0, 1'b0);
    bus.start_ext = 1'b0;
  endtask

  initial begin
    logic [W-1:0] last;
    checks = 0;
    errors = 0;
    m_q    = '0;
    m_sout = 1'b0;

    // reset held with random inputs
    rst_ext_n      = 1'b0;
    bus.enable_ext = 1'b1;
    bus.sin_ext    = 1'b0;
    drive_noise();
    repeat (3) begin
      @(negedge clk);
      check_all("reset", 1'b0, 1'b0);
      drive_noise();
    end
    rst_ext_n     = 1'b1;
    bus.start_ext = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_all("post_reset", 1'b0, 1'b0);
    end

    // load 0xA5
    cmd(3'd1, 3'd0, 8'hA5, 1'b0, 0, 0);
    check("load_val", bus.q, 8'hA5);

    // rotate left 3 with start pulses during busy
    cmd(3'd4, 3'd3, 8'h00, 1'b1, 2, 0);
    check("rol_val", bus.q, 8'h2D);
    check("rol_sout", W'(bus.sout), 8'h01);
    check("rol_hist", exp_q[exp_q.size()-3], 8'h4B);

    // ASR 2 from 0xA5, then zero-count SHR
    cmd(3'd1, 3'd0, 8'hA5, 1'b0, 0, 0);
    cmd(3'd6, 3'd2, 8'h00, 1'b0, 2, 0);
    check("asr_val", bus.q, 8'hE9);
    check("asr_sout", W'(bus.sout), 8'h00);
    cmd(3'd3, 3'd0, 8'h00, 1'b0, 2, 0);
    check("shr0_val", bus.q, 8'hE9);

    // HOLD keeps q
    cmd(3'd0, 3'd5, 8'h11, 1'b0, 2, 0);
    check("hold_val", bus.q, 8'hE9);

    // stall during SHL 4 with sin=1
    cmd(3'd7, 3'd0, 8'h00, 1'b0, 0, 0);
    cmd(3'd2, 3'd4, 8'h00, 1'b0, 1, 2);
    check("stall_val", bus.q, 8'h0F);

    // abort ROR 7 by asynchronous reset between edges
    cmd(3'd1, 3'd0, 8'hA5, 1'b0, 0, 0);
    bus.start_ext = 1'b1;
    bus.mode_ext  = 3'd5;
    bus.shamt_ext = 3'd7;
    @(posedge clk);
    model_step(3'd5, bus.sin_ext);
    @(negedge clk);
    check_all("abort_s1", 1'b1, 1'b0);
    bus.start_ext = 1'b0;
    @(posedge clk);
    model_step(3'd5, bus.sin_ext);
    @(negedge clk);
    #2 rst_ext_n = 1'b0;
    #1;
    m_q    = '0;
    m_sout = 1'b0;
    check_all("abort", 1'b0, 1'b0);
    @(negedge clk);
    rst_ext_n = 1'b1;
    @(negedge clk);
    check_all("abort_idle", 1'b0, 1'b0);
    cmd(3'd1, 3'd0, 8'h3C, 1'b0, 0, 0);
    check("reload_val", bus.q, 8'h3C);

    // randomized commands
    for (int i = 0; i < 30; i++) begin
      logic [2:0]    rm;
      logic [SW-1:0] rs;
      rm = 3'($urandom_range(0, 7));
      rs = SW'($urandom_range(0, 7));
      cmd(rm, rs, W'($urandom), 1'($urandom),
          2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_all("rand_gap", 1'b0, 1'b0);
      end
    end

    last = exp_q[exp_q.size()-1];
    check("final_model", bus.q, last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
